// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the dump-engine state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 8;
  localparam int NUM_REGS   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Bundle between the register dump engine, the register-file read port and the word sink.
// Latency: none (wires only).
// Backpressure: DVALID/DREADY handshake on the DOUT/DIDX stream.
// Ports: START/FIRST/LAST request, RADDR/RDATA read port, DOUT/DIDX/DVALID/DREADY stream,
//        BUSY/DONE status. The slave side is the engine; the master side is everything
//        around it (requester, register file and sink together).
interface reg_dump_reader_if #(
  parameter int DATA_WIDTH = cpu_pkg::REG_DATA_W,
  parameter int ADDR_WIDTH = cpu_pkg::REG_ADDR_W
);

  logic                  START;
  logic [ADDR_WIDTH-1:0] FIRST;
  logic [ADDR_WIDTH-1:0] LAST;
  logic [ADDR_WIDTH-1:0] RADDR;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [DATA_WIDTH-1:0] DOUT;
  logic [ADDR_WIDTH-1:0] DIDX;
  logic                  DVALID;
  logic                  DREADY;
  logic                  BUSY;
  logic                  DONE;

  modport slave (
    input  START, FIRST, LAST, RDATA, DREADY,
    output RADDR, DOUT, DIDX, DVALID, BUSY, DONE
  );

  modport master (
    output START, FIRST, LAST, RDATA, DREADY,
    input  RADDR, DOUT, DIDX, DVALID, BUSY, DONE
  );

endinterface

// File: rtl/reg_dump_reader.sv
// Walks one register-file read port over an inclusive, optionally wrapping index range.
// Latency: first word valid READ_LAT cycles after START; one word per READ_LAT+1 cycles.
// Backpressure: a presented word is held until DREADY; no further reads are issued meanwhile.
// Ports: CLK, RESET (async, active low), bus (slave side of reg_dump_reader_if).
module reg_dump_reader
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int READ_LAT   = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  reg_dump_reader_if.slave bus
);

  // Wait counter is 3 bits, enough for read latencies 1..7.
  localparam logic [2:0] LAT_INIT = 3'(READ_LAT);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

  state_t                state_q,  state_d;
  logic [ADDR_WIDTH-1:0] idx_q,    idx_d;
  logic [ADDR_WIDTH-1:0] last_q,   last_d;
  logic [ADDR_WIDTH-1:0] raddr_q,  raddr_d;
  logic [DATA_WIDTH-1:0] dout_q,   dout_d;
  logic [ADDR_WIDTH-1:0] didx_q,   didx_d;
  logic                  dvalid_q, dvalid_d;
  logic [2:0]            cnt_q,    cnt_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= '0;
      raddr_q  <= '0;
      dout_q   <= '0;
      didx_q   <= '0;
      dvalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      raddr_q  <= raddr_d;
      dout_q   <= dout_d;
      didx_q   <= didx_d;
      dvalid_q <= dvalid_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    raddr_d  = raddr_q;
    dout_d   = dout_q;
    didx_d   = didx_q;
    dvalid_d = dvalid_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          idx_d   = bus.FIRST;
          last_d  = bus.LAST;
          raddr_d = bus.FIRST;
          cnt_d   = LAT_INIT;
          state_d = SETUP;
        end
      end

      SETUP: begin
        cnt_d = cnt_q - 3'd1;
        // Counter at 1 means RDATA for raddr_q is valid on this edge.
        if (cnt_q == 3'd1) begin
          dout_d   = bus.RDATA;
          didx_d   = idx_q;
          dvalid_d = 1'b1;
          state_d  = PRESENT;
        end
      end

      PRESENT: begin
        // DOUT is a private copy, so register-file writes here cannot disturb it.
        if (dvalid_q && bus.DREADY) begin
          dvalid_d = 1'b0;
          if (idx_q == last_q) begin
            state_d = DONE;
          end else begin
            // Natural overflow of the index gives the 7->0 wrap.
            idx_d   = idx_q + IDX_ONE;
            raddr_d = idx_q + IDX_ONE;
            cnt_d   = LAT_INIT;
            state_d = SETUP;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags decode the state register directly, so they stay register-driven.
  assign bus.RADDR  = raddr_q;
  assign bus.DOUT   = dout_q;
  assign bus.DIDX   = didx_q;
  assign bus.DVALID = dvalid_q;
  assign bus.BUSY   = (state_q != IDLE);
  assign bus.DONE   = (state_q == DONE);

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Sequential read-out engine for the 8x8 CPU register file. On a START request it walks one register-file read port over an inclusive, optionally wrapping index range. For each index it waits a fixed read latency, captures the word, and presents it on a valid/ready stream for a debug, trace or UART sink. It sits beside the register file on a dedicated read-address mux leg, which is selected only while BUSY is high, and never writes the register file.

## Interface
- DATA_WIDTH, 8, register word width
- ADDR_WIDTH, 3, register index width
- READ_LAT, 1, cycles from RADDR change to RDATA valid; legal range 1..7
- CLK  in  1  single clock; all state updates on posedge
- RESET  in  1  asynchronous, active-low reset
- START  in  1  request pulse; sampled only in IDLE
- FIRST  in  ADDR_WIDTH  first index; latched with START
- LAST  in  ADDR_WIDTH  last index, inclusive; latched with START
- RADDR  out  ADDR_WIDTH  read address driven to the register file
- RDATA  in  DATA_WIDTH  register-file read data
- DOUT  out  DATA_WIDTH  captured word
- DIDX  out  ADDR_WIDTH  index of DOUT
- DVALID  out  1  DOUT/DIDX valid
- DREADY  in  1  sink accepts when DVALID && DREADY
- BUSY  out  1  high in SETUP, PRESENT and DONE
- DONE  out  1  one-cycle pulse after the last word is accepted

## Operation
- States: IDLE, SETUP, PRESENT, DONE.
- **IDLE**
  - START=1: latch FIRST into idx and LAST into last_q, drive RADDR=FIRST, load wait counter with READ_LAT, go to SETUP.
  - FIRST and LAST are ignored outside IDLE.
- **SETUP**
  - Decrement the wait counter each cycle.
  - On the edge where the counter equals 1: capture RDATA into DOUT and idx into DIDX, set DVALID=1, go to PRESENT.
- **PRESENT**
  - DOUT, DIDX and DVALID are held stable until the handshake completes.
  - RDATA changes, such as CPU writes, do not affect DOUT.
  - On DVALID && DREADY, clear DVALID, then:
    - idx==last_q: go to DONE.
    - Otherwise: idx = (idx+1) mod 2^ADDR_WIDTH, RADDR=idx, reload the counter, go to SETUP.
- **DONE**
  - DONE=1 for exactly one cycle, then go to IDLE.
  - START is ignored in DONE.
- Range rules:
  - LAST ≥ FIRST: LAST−FIRST+1 words.
  - LAST < FIRST: wraps 7→0, giving 8−FIRST+LAST+1 words.
  - FIRST==LAST: exactly one word.
- START is ignored while BUSY; there is no queuing.
- RESET low at any time, including mid-dump: immediate return to IDLE. The partial dump is discarded and DONE is not pulsed.

## Timing
- Reset values: RADDR=0, DOUT=0, DIDX=0, DVALID=0, BUSY=0, DONE=0.
- All outputs are registered; there are no combinational paths from any input to any output.
- START accepted at edge n:
  - RADDR=FIRST and BUSY=1 from n.
  - First DVALID rises at edge n+READ_LAT.
- Per word: READ_LAT cycles in SETUP plus at least 1 cycle in PRESENT.
- Throughput with DREADY held high: one word every READ_LAT+1 cycles.
- Full 0→7 dump, READ_LAT=1, DREADY=1: 16 cycles from START to the last acceptance, then DONE for 1 cycle, then BUSY=0.
- DREADY may be high before DVALID. Acceptance happens only on an edge where both are 1.
- RADDR changes only when entering SETUP. It is stable for the whole SETUP/PRESENT pair of its index.

## Structure
- Shared package cpu_pkg holds:
  - the state enum: IDLE, SETUP, PRESENT, DONE;
  - REG_ADDR_W=3 and REG_DATA_W=8;
  - NUM_REGS=8.
- The wait counter is 3 bits wide, which covers READ_LAT up to 7.
- Single module with no sub-modules. The FSM, index counter and wait counter are simple enough to keep inline.

## Test plan
- Reset the regfile model, load reg k = 8'h10+k, FIRST=0, LAST=7, DREADY=1, READ_LAT=1 → 8 words 10..17 with DIDX 0..7, one every 2 cycles. DONE pulses once, then BUSY=0.
- FIRST=6, LAST=1 → wrap order 6,7,0,1 (4 words), then DONE.
- FIRST=LAST=3, DREADY low for 5 cycles after DVALID → DOUT=8'h13 and DIDX=3 held stable for all 5 cycles. Exactly one accept, then DONE.
- Write reg 2 = 8'hAA while index 2 is in PRESENT → DOUT keeps the captured value. START pulsed mid-dump is ignored, and the word count is unchanged.
- Assert RESET low during the third word → all outputs zero asynchronously and no DONE. A following START runs a full, correct dump.
- READ_LAT=3 sweep → DVALID rises 3 cycles after each RADDR change, with correct data.
